truth_table_sweeper: RTL and testbench

- Sequential stimulus/response engine: the driving end of the 4-input combinational gate-level function interface (inputs x, y, w, z; output s).
- On start, it walks all 16 input combinations and drives them to the function under test.
- For each combination it waits a settle window, samples s, and builds a 16-bit response signature.
- It compares the signature against an expected truth table and reports pass/fail, mismatch count and the first failing vector. It sits beside the gate-level function on the lab board as a self-checking harness.

---
 rtl/truth_table_sweeper.sv | 131 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks all 16 {x,y,w,z} vectors into a 4-input function,
// samples its response after a settle window and scores it against a truth table.
module truth_table_sweeper #(
   parameter int unsigned SETTLE   = 1,
   parameter logic [15:0] EXPECTED = 16'h7310
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        s_in,
   output logic [3:0]  vec_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] captured,
   output logic        pass,
   output logic [4:0]  mismatch_count,
   output logic [3:0]  first_fail,
   output logic        fail_valid
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned VEC_W = 4;
   localparam int unsigned SIG_W = 16;
   localparam int unsigned MM_W  = 5;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] HOLD   = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
   localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(15);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [VEC_W-1:0] vec_d;
   logic             busy_d, done_d, pass_d, fail_valid_d;
   logic [SIG_W-1:0] captured_d;
   logic [MM_W-1:0]  mismatch_count_d;
   logic [VEC_W-1:0] first_fail_d;

   // State, counter and all outputs are registered; reset clears everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         vec_out        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         captured       <= '0;
         pass           <= 1'b0;
         mismatch_count <= '0;
         first_fail     <= '0;
         fail_valid     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         vec_out        <= vec_d;
         busy           <= busy_d;
         done           <= done_d;
         captured       <= captured_d;
         pass           <= pass_d;
         mismatch_count <= mismatch_count_d;
         first_fail     <= first_fail_d;
         fail_valid     <= fail_valid_d;
      end
   end

   // Next-state and next-output logic for the sweep sequencer.
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      vec_d            = vec_out;
      busy_d           = busy;
      done_d           = done;
      captured_d       = captured;
      pass_d           = pass;
      mismatch_count_d = mismatch_count;
      first_fail_d     = first_fail;
      fail_valid_d     = fail_valid;

      case (state_q)
         IDLE, DONE: begin
            // start is only honoured when no sweep is running
            if (start) begin
               state_d          = HOLD;
               cnt_d            = '0;
               vec_d            = '0;
               busy_d           = 1'b1;
               done_d           = 1'b0;
               captured_d       = '0;
               pass_d           = 1'b0;
               mismatch_count_d = '0;
               first_fail_d     = '0;
               fail_valid_d     = 1'b0;
            end
         end
         HOLD: begin
            // HOLD lasts SETTLE+1 cycles; leave on the edge the counter hits SETTLE
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == SETTLE_CNT) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            captured_d[vec_out] = s_in;
            if (s_in != EXPECTED[vec_out]) begin
               mismatch_count_d = mismatch_count + MM_W'(1);
               if (!fail_valid) begin
                  first_fail_d = vec_out;
                  fail_valid_d = 1'b1;
               end
            end
            if (vec_out != LAST_VEC) begin
               vec_d   = vec_out + VEC_W'(1);
               cnt_d   = '0;
               state_d = HOLD;
            end else begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (captured_d == EXPECTED);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps against ideal, stuck-at and faulted
// function models, with restart, busy-start and async-reset cases.
module tb_truth_table_sweeper;

   logic        clk = 1'b0;
   logic        reset;
   int          mode;   // 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 ideal with vector 15 flipped

   // SETTLE=1 instance
   logic        start1, s_in1;
   logic [3:0]  vec1, ff1;
   logic        busy1, done1, pass1, fv1;
   logic [15:0] cap1;
   logic [4:0]  mm1;

   // SETTLE=0 instance
   logic        start0, s_in0;
   logic [3:0]  vec0, ff0;
   logic        busy0, done0, pass0, fv0;
   logic [15:0] cap0;
   logic [4:0]  mm0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   truth_table_sweeper #(.SETTLE(1), .EXPECTED(16'h7310)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .s_in(s_in1),
      .vec_out(vec1), .busy(busy1), .done(done1), .captured(cap1),
      .pass(pass1), .mismatch_count(mm1), .first_fail(ff1), .fail_valid(fv1)
   );

   truth_table_sweeper #(.SETTLE(0), .EXPECTED(16'h7310)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .s_in(s_in0),
      .vec_out(vec0), .busy(busy0), .done(done0), .captured(cap0),
      .pass(pass0), .mismatch_count(mm0), .first_fail(ff0), .fail_valid(fv0)
   );

   // Function under test: s = x&~w | y&~w&~z | x&y&~z, with fault options
   function automatic logic model(input int m, input logic [3:0] v);
      logic x, y, w, z, s;
      x = v[3]; y = v[2]; w = v[1]; z = v[0];
      s = (x & ~w) | (y & ~w & ~z) | (x & y & ~z);
      case (m)
         1:       model = 1'b0;
         2:       model = 1'b1;
         3:       model = (v == 4'd15) ? ~s : s;
         default: model = s;
      endcase
   endfunction

   always_comb s_in1 = model(mode, vec1);
   always_comb s_in0 = model(mode, vec0);

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Raise start1 now (at a negedge) and drop it at the next negedge, just after the start edge
   task automatic kick1();
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start1 = 1'b0; start0 = 1'b0; mode = 0;
      #2;
      check("rst_vec",  16'(vec1), 16'h0);
      check("rst_busy", 16'(busy1), 16'h0);
      check("rst_done", 16'(done1), 16'h0);
      check("rst_cap",  cap1, 16'h0);
      check("rst_pass", 16'(pass1), 16'h0);
      check("rst_mm",   16'(mm1), 16'h0);
      check("rst_fv",   16'(fv1), 16'h0);
      check("rst_ff",   16'(ff1), 16'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Ideal model, SETTLE=1: 48 cycles
      mode = 0;
      kick1();
      check("ideal_busy0", 16'(busy1), 16'h1);
      check("ideal_vec0",  16'(vec1), 16'h0);
      repeat (47) @(negedge clk);
      check("ideal_done47", 16'(done1), 16'h0);
      @(negedge clk);
      check("ideal_done48", 16'(done1), 16'h1);
      check("ideal_busy48", 16'(busy1), 16'h0);
      check("ideal_cap",    cap1, 16'h7310);
      check("ideal_pass",   16'(pass1), 16'h1);
      check("ideal_mm",     16'(mm1), 16'h0);
      check("ideal_fv",     16'(fv1), 16'h0);
      check("ideal_vec15",  16'(vec1), 16'hF);

      // Stuck-at-0, SETTLE=0: 32 cycles
      mode = 1;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (31) @(negedge clk);
      check("sa0_done31", 16'(done0), 16'h0);
      @(negedge clk);
      check("sa0_done32", 16'(done0), 16'h1);
      check("sa0_cap",    cap0, 16'h0000);
      check("sa0_pass",   16'(pass0), 16'h0);
      check("sa0_mm",     16'(mm0), 16'd6);
      check("sa0_ff",     16'(ff0), 16'd4);
      check("sa0_fv",     16'(fv0), 16'h1);

      // Stuck-at-1, SETTLE=1, then idle in DONE
      mode = 2;
      kick1();
      repeat (48) @(negedge clk);
      check("sa1_cap", cap1, 16'hFFFF);
      check("sa1_mm",  16'(mm1), 16'd10);
      check("sa1_ff",  16'(ff1), 16'd0);
      check("sa1_fv",  16'(fv1), 16'h1);
      repeat (10) @(negedge clk);
      check("sa1_busy_hold", 16'(busy1), 16'h0);
      check("sa1_done_hold", 16'(done1), 16'h1);
      check("sa1_vec_hold",  16'(vec1), 16'hF);

      // Vector 15 fault, restarting from DONE
      mode = 3;
      kick1();
      check("rearm_done", 16'(done1), 16'h0);
      check("rearm_vec",  16'(vec1), 16'h0);
      check("rearm_cap",  cap1, 16'h0);
      check("rearm_mm",   16'(mm1), 16'h0);
      repeat (48) @(negedge clk);
      check("v15_cap",  cap1, 16'hF310);
      check("v15_mm",   16'(mm1), 16'd1);
      check("v15_ff",   16'(ff1), 16'd15);
      check("v15_pass", 16'(pass1), 16'h0);

      // start pulsed at vector 5 is ignored
      mode = 0;
      kick1();
      repeat (16) @(negedge clk);
      check("busy_start_vec5", 16'(vec1), 16'd5);
      kick1();
      check("busy_start_nores", 16'(vec1), 16'd5);
      repeat (30) @(negedge clk);
      check("busy_start_done47", 16'(done1), 16'h0);
      @(negedge clk);
      check("busy_start_done48", 16'(done1), 16'h1);
      check("busy_start_pass",   16'(pass1), 16'h1);

      // Restart, then async reset at vector 9 between edges
      kick1();
      repeat (28) @(negedge clk);
      check("mid_vec9", 16'(vec1), 16'd9);
      #1 reset = 1'b1;
      #1;
      check("arst_vec",  16'(vec1), 16'h0);
      check("arst_busy", 16'(busy1), 16'h0);
      check("arst_cap",  cap1, 16'h0);
      check("arst_fv",   16'(fv1), 16'h0);
      check("arst_done", 16'(done1), 16'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      kick1();
      repeat (48) @(negedge clk);
      check("post_rst_done", 16'(done1), 16'h1);
      check("post_rst_cap",  cap1, 16'h7310);
      check("post_rst_pass", 16'(pass1), 16'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
